// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding, default width, counter sizing.
// Optional carry-in is controlled by SERIAL_ADDER_CIN_EN in the interface and top.
package serial_adder_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Bit counter must reach WIDTH-1; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder; cin exists only with SERIAL_ADDER_CIN_EN.
interface serial_adder_if
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_CIN_EN
   logic             cin;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b,
`ifdef SERIAL_ADDER_CIN_EN
      output cin,
`endif
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b,
`ifdef SERIAL_ADDER_CIN_EN
      input  cin,
`endif
      output busy, done, sum, cout
   );

endinterface

// File: rtl/fulladder.sv
// One-bit full adder used as the serial datapath core.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ c;
   assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per cycle through a single full adder, LSB first.
// SERIAL_ADDER_CIN_EN adds a carry-in that seeds the carry register on start.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   serial_adder_if.slave  bus
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fa_s;
   logic             fa_co;
   logic             seed;

   fulladder u_fa (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .c  (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

`ifdef SERIAL_ADDER_CIN_EN
   assign seed = bus.cin;
`else
   assign seed = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               res_d   = '0;
               carry_d = seed;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               sum_d   = {fa_s, res_q[WIDTH-1:1]};
               cout_d  = fa_co;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

   a_busy_done_excl: assert property (@(posedge clk) !(busy_q && done_q));

endmodule
